act_sparse_encoder: RTL

//  Encoder counterpart of the activation pre-process select unit: accepts one dense

---
 rtl/act_sparse_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/act_sparse_encoder.sv
// Sparse activation encoder: takes one dense block and streams its nonzero entries
// as (value, index) beats in ascending index order, with a marker beat for an all-zero block.
module act_sparse_encoder #(
   parameter int DATA_WIDTH   = 8,
   parameter int BLOCK_NUMBER = 16,
   parameter int INDEX_WIDTH  = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] Input_act_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH-1:0]              Output_act_data,
   output logic [INDEX_WIDTH-1:0]             mask,
   output logic                               out_last,
   output logic                               out_empty,
   output logic [INDEX_WIDTH:0]               nnz_count
);

   // state   | meaning
   // ST_IDLE | waiting for a dense block, in_ready high
   // ST_EMIT | presenting beats for the held block until the last one handshakes
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;

   logic [DATA_WIDTH-1:0]   entry_q [BLOCK_NUMBER];
   logic [BLOCK_NUMBER-1:0] nz_q;
   logic [INDEX_WIDTH:0]    nnz_q;

   logic [BLOCK_NUMBER-1:0] in_nz;
   logic [INDEX_WIDTH:0]    in_nnz;
   logic [INDEX_WIDTH-1:0]  first_idx;
   logic                    nz_none;
   logic                    nz_single;
   logic                    accept;
   logic                    beat_done;

   assign accept    = in_valid && in_ready;
   assign beat_done = out_valid && out_ready;

   always_comb begin
      in_nz  = '0;
      in_nnz = '0;
      for (int i = 0; i < BLOCK_NUMBER; i++) begin
         in_nz[i] = |Input_act_data[i*DATA_WIDTH +: DATA_WIDTH];
         in_nnz   = in_nnz + (INDEX_WIDTH+1)'(in_nz[i]);
      end
   end

   // Lowest set bit wins, so beats come out in ascending index order.
   always_comb begin
      first_idx = '0;
      for (int i = BLOCK_NUMBER - 1; i >= 0; i--) begin
         if (nz_q[i]) begin
            first_idx = INDEX_WIDTH'(i);
         end
      end
   end

   assign nz_none   = (nz_q == '0);
   assign nz_single = !nz_none && ((nz_q & (nz_q - BLOCK_NUMBER'(1))) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (beat_done && out_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from registered state only; nothing from the inputs reaches them.
   always_comb begin
      in_ready        = 1'b0;
      out_valid       = 1'b0;
      out_last        = 1'b0;
      out_empty       = 1'b0;
      Output_act_data = '0;
      mask            = '0;
      nnz_count       = '0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            out_last  = nz_single || nz_none;
            out_empty = nz_none;
            nnz_count = nnz_q;
            if (!nz_none) begin
               Output_act_data = entry_q[first_idx];
               mask            = first_idx;
            end
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BLOCK_NUMBER; i++) begin
            entry_q[i] <= '0;
         end
         nz_q  <= '0;
         nnz_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < BLOCK_NUMBER; i++) begin
            entry_q[i] <= Input_act_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
         nz_q  <= in_nz;
         nnz_q <= in_nnz;
      end else if (beat_done && !nz_none) begin
         nz_q[first_idx] <= 1'b0;
      end
   end

endmodule
